// File: rtl/dpram_stream_pkg.sv
// -----------------------------------------------------------------------------
// dpram_stream_pkg
// Shared definitions for the DPRAM byte streamer: FSM state encoding, byte
// order and length-prefix constants, and the helper that clamps the requested
// payload length to the DPRAM capacity.
// -----------------------------------------------------------------------------
package dpram_stream_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PREFIX_HI = 3'd1,
        S_PREFIX_LO = 3'd2,
        S_FETCH     = 3'd3,
        S_RD_WAIT   = 3'd4,
        S_SEND      = 3'd5,
        S_DONE      = 3'd6
    } stream_state_e;

    // Bytes of a DPRAM word leave in order 31:24, 23:16, 15:8, 7:0.
    localparam bit BYTE_ORDER_MSB_FIRST = 1'b1;

    // Width of the byte-count prefix sent ahead of the payload.
    localparam int PREFIX_W = 16;

    // Capacity is 4 * 2^adr_w bytes. From adr_w = 14 upward the capacity is
    // at least 65536, so no 16-bit length can exceed it.
    function automatic logic [PREFIX_W-1:0] clamp_len(input logic [PREFIX_W-1:0] len,
                                                      input int unsigned adr_w);
        logic [PREFIX_W:0] cap;
        if (adr_w >= 14) begin
            return len;
        end
        cap = (PREFIX_W + 1)'(32'd4 << adr_w);
        if ({1'b0, len} > cap) begin
            return cap[PREFIX_W-1:0];
        end
        return len;
    endfunction

endpackage

// File: rtl/dpram_byte_streamer_serializer.sv
// -----------------------------------------------------------------------------
// word_byte_serializer
// Loads one 32-bit word together with the number of its leading bytes to emit
// (1..4) and shifts those bytes out under a valid/ready handshake.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset (drops any pending bytes)
//   load          : capture load_data / load_cnt this cycle
//   load_data     : word to serialize
//   load_cnt      : number of bytes of the word to emit, 1..4
//   out_data      : current byte
//   out_valid     : a byte is pending
//   out_ready     : consumer accepts out_data this cycle
//   out_last      : the final loaded byte transfers this cycle
// -----------------------------------------------------------------------------
module word_byte_serializer
    import dpram_stream_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic [2:0]  load_cnt,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last
);

    logic [31:0] shreg_q, shreg_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        fire;

    assign fire      = out_valid && out_ready;
    assign out_valid = (cnt_q != 3'd0);
    assign out_last  = fire && (cnt_q == 3'd1);
    assign out_data  = BYTE_ORDER_MSB_FIRST ? shreg_q[31:24] : shreg_q[7:0];

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load) begin
            shreg_d = load_data;
            cnt_d   = load_cnt;
        end else if (fire) begin
            // The byte on out_data only moves once the consumer has taken it.
            shreg_d = BYTE_ORDER_MSB_FIRST ? {shreg_q[23:0], 8'h00}
                                           : {8'h00, shreg_q[31:8]};
            cnt_d   = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/dpram_byte_streamer.sv
// -----------------------------------------------------------------------------
// dpram_byte_streamer
// Drains the DPRAM after the waveform buffer reader signals dpram_run: holds
// dpram_busy for the whole drain, optionally sends the 16-bit (clamped) byte
// count MSB first, then reads the stored words from address 0 upward and
// streams their bytes MSB first toward the host link.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset (aborts a drain)
//   dpram_run      : one-cycle start pulse, honoured only when idle
//   dpram_len      : payload length in bytes, sampled with dpram_run
//   dpram_busy     : high from the cycle after dpram_run through drain_done
//   dpram_rd_addr  : DPRAM word read address
//   dpram_rd_data  : DPRAM read data, P_RD_LATENCY cycles after the address
//   tx_data/valid  : byte stream toward the host link
//   tx_ready       : link accepts tx_data this cycle
//   drain_done     : one-cycle pulse after the final byte has transferred
// -----------------------------------------------------------------------------
module dpram_byte_streamer
    import dpram_stream_pkg::*;
#(
    parameter int P_DPRAM_ADR_WIDTH = 10,
    parameter int P_RD_LATENCY      = 1,
    parameter int P_LEN_PREFIX      = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         dpram_run,
    input  logic [15:0]                  dpram_len,
    output logic                         dpram_busy,
    output logic [P_DPRAM_ADR_WIDTH-1:0] dpram_rd_addr,
    input  logic [31:0]                  dpram_rd_data,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         drain_done
);

    localparam logic [1:0] RD_LAT = 2'(P_RD_LATENCY);

    stream_state_e                state_q, state_d;
    logic [PREFIX_W-1:0]          len_q, len_d;
    logic [15:0]                  byte_cnt_q, byte_cnt_d;
    logic [P_DPRAM_ADR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]                   lat_q, lat_d;
    logic [16:0]                  remain;

    logic                         ser_load;
    logic [2:0]                   ser_cnt;
    logic [7:0]                   ser_data;
    logic                         ser_valid;
    logic                         ser_ready;
    logic                         ser_last;

    word_byte_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .load_data (dpram_rd_data),
        .load_cnt  (ser_cnt),
        .out_data  (ser_data),
        .out_valid (ser_valid),
        .out_ready (ser_ready),
        .out_last  (ser_last)
    );

    // Any non-idle state owns the DPRAM, so busy follows the state register and
    // rises exactly one cycle after an accepted run.
    assign dpram_busy    = (state_q != S_IDLE);
    assign dpram_rd_addr = addr_q;

    // byte_cnt_q counts bytes already loaded into the serializer; the 17-bit
    // difference keeps len = 0xFFFF from wrapping.
    assign remain = {1'b0, len_q} - {1'b0, byte_cnt_q};

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        lat_d      = lat_q;
        ser_load   = 1'b0;
        ser_cnt    = 3'd0;
        ser_ready  = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        drain_done = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (dpram_run) begin
                    len_d      = clamp_len(dpram_len, P_DPRAM_ADR_WIDTH);
                    byte_cnt_d = '0;
                    addr_d     = '0;
                    state_d    = (P_LEN_PREFIX != 0) ? S_PREFIX_HI : S_FETCH;
                end
            end
            S_PREFIX_HI: begin
                tx_valid = 1'b1;
                tx_data  = len_q[15:8];
                if (tx_ready) state_d = S_PREFIX_LO;
            end
            S_PREFIX_LO: begin
                tx_valid = 1'b1;
                tx_data  = len_q[7:0];
                if (tx_ready) state_d = S_FETCH;
            end
            S_FETCH: begin
                // addr_q is already on the bus; an empty payload never reads.
                if (remain == 17'd0) begin
                    state_d = S_DONE;
                end else begin
                    lat_d   = 2'd1;
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (lat_q == RD_LAT) begin
                    ser_load   = 1'b1;
                    ser_cnt    = (remain >= 17'd4) ? 3'd4 : remain[2:0];
                    byte_cnt_d = byte_cnt_q + {13'd0, ser_cnt};
                    state_d    = S_SEND;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_SEND: begin
                tx_valid  = ser_valid;
                tx_data   = ser_data;
                ser_ready = tx_ready;
                if (ser_last) begin
                    if (remain == 17'd0) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + P_DPRAM_ADR_WIDTH'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                drain_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            byte_cnt_q <= '0;
            addr_q     <= '0;
            lat_q      <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            lat_q      <= lat_d;
        end
    end

endmodule

// File: tb/tb_dpram_byte_streamer.sv
// -----------------------------------------------------------------------------
// tb_dpram_byte_streamer
// Randomized bench for dpram_byte_streamer with a byte-queue reference model
// and a few literal byte sequences for the directed cases.
// -----------------------------------------------------------------------------
module tb_dpram_byte_streamer;

    localparam int ADR_W = 2;
    localparam int LAT   = 1;
    localparam int PFX   = 1;
    localparam int CAP   = 4 << ADR_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             dpram_run = 1'b0;
    logic [15:0]      dpram_len = 16'd0;
    logic             dpram_busy;
    logic [ADR_W-1:0] dpram_rd_addr;
    logic [31:0]      dpram_rd_data;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             drain_done;

    always #5 clk = ~clk;

    dpram_byte_streamer #(
        .P_DPRAM_ADR_WIDTH (ADR_W),
        .P_RD_LATENCY      (LAT),
        .P_LEN_PREFIX      (PFX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dpram_run     (dpram_run),
        .dpram_len     (dpram_len),
        .dpram_busy    (dpram_busy),
        .dpram_rd_addr (dpram_rd_addr),
        .dpram_rd_data (dpram_rd_data),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .drain_done    (drain_done)
    );

    // DPRAM with a fixed read latency.
    logic [31:0] mem     [2**ADR_W];
    logic [31:0] rd_pipe [LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= mem[dpram_rd_addr];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign dpram_rd_data = rd_pipe[LAT-1];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] pin_q[$];
    bit         active = 0, start_pending = 0, done_prev = 0, rst_prev = 0;
    bit         prev_valid = 0, prev_ready = 0;
    logic [7:0] prev_data = 8'h00;
    int         active_cycles = 0, max_addr = 0, max_seen = 0;
    int         xfer_cnt = 0, done_cnt = 0;

    // Expected byte stream: clamped length prefix, then the first
    // min(len, capacity) bytes of the memory image, MSB of each word first.
    task automatic build_exp(input logic [15:0] len);
        int          cl;
        logic [31:0] w;
        cl = (int'(len) > CAP) ? CAP : int'(len);
        exp_q.delete();
        if (PFX != 0) begin
            exp_q.push_back(8'(cl >> 8));
            exp_q.push_back(8'(cl));
        end
        for (int i = 0; i < cl; i++) begin
            w = mem[ADR_W'(i / 4)];
            exp_q.push_back(w[31 - 8 * (i % 4) -: 8]);
        end
        max_addr = (cl == 0) ? 0 : (cl + 3) / 4 - 1;
    endtask

    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                active        = 0;
                start_pending = 0;
                done_prev     = 0;
                rst_prev      = 1;
                prev_valid    = 0;
            end else begin
                if (rst_prev) begin
                    check("rst_tx_data", 32'(tx_data), 32'd0);
                    check("rst_addr", 32'(dpram_rd_addr), 32'd0);
                    rst_prev = 0;
                end
                if (done_prev) begin
                    active    = 0;
                    done_prev = 0;
                end
                if (start_pending) begin
                    active        = 1;
                    start_pending = 0;
                    active_cycles = 0;
                end
                if (active) begin
                    active_cycles++;
                    check("busy_active", 32'(dpram_busy), 32'd1);
                    check("addr_range", 32'(int'(dpram_rd_addr) <= max_addr), 32'd1);
                    if (int'(dpram_rd_addr) > max_seen) max_seen = int'(dpram_rd_addr);
                    if (prev_valid && !prev_ready) begin
                        check("hold_valid", 32'(tx_valid), 32'd1);
                        check("hold_data", 32'(tx_data), 32'(prev_data));
                    end
                    if (tx_valid && tx_ready) begin
                        check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("tx_byte", 32'(tx_data), 32'(e));
                        end
                        got_q.push_back(tx_data);
                        xfer_cnt++;
                    end
                    if (drain_done) begin
                        check("done_all_sent", 32'(exp_q.size()), 32'd0);
                        check("busy_min2", 32'(active_cycles >= 2), 32'd1);
                        done_prev = 1;
                        done_cnt++;
                    end
                end else begin
                    check("idle_busy", 32'(dpram_busy), 32'd0);
                    check("idle_valid", 32'(tx_valid), 32'd0);
                    check("idle_done", 32'(drain_done), 32'd0);
                    if (dpram_run) begin
                        build_exp(dpram_len);
                        start_pending = 1;
                        got_q.delete();
                        max_seen = 0;
                    end
                end
                prev_valid = tx_valid;
                prev_ready = tx_ready;
                prev_data  = tx_data;
            end
        end
    end

    // ---------------- tx_ready driver ----------------
    int ready_mode = 0;  // 0: always ready, 1: alternate, 2: random
    bit force_ready_low = 0;
    initial begin
        bit toggle;
        toggle   = 0;
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            toggle = ~toggle;
            if (force_ready_low)      tx_ready = 1'b0;
            else if (ready_mode == 0) tx_ready = 1'b1;
            else if (ready_mode == 1) tx_ready = toggle;
            else                      tx_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply_reset(input int cycles);
        force_ready_low = 1;
        @(posedge clk); #1 rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
        force_ready_low = 0;
    endtask

    task automatic start_run(input logic [15:0] len);
        @(posedge clk); #1;
        dpram_run = 1'b1;
        dpram_len = len;
        @(posedge clk); #1;
        dpram_run = 1'b0;
        dpram_len = 16'($urandom);
    endtask

    task automatic do_run(input logic [15:0] len, input bit extra);
        int n, d0;
        bit ok;
        d0 = done_cnt;
        start_run(len);
        n = 0;
        while (!(done_cnt != d0 && !active) && n < 3000) begin
            @(posedge clk); #1;
            n++;
            dpram_run = (extra && n == 5);
            if (dpram_run) dpram_len = 16'd4;
        end
        dpram_run = 1'b0;
        ok = (done_cnt == d0 + 1) && !active;
        check("drain_finished", 32'(ok), 32'd1);
        if (!ok) apply_reset(2);
    endtask

    task automatic pin_check(input string name);
        check({name, "_count"}, 32'(got_q.size()), 32'(pin_q.size()));
        for (int i = 0; i < pin_q.size() && i < got_q.size(); i++)
            check(name, 32'(got_q[i]), 32'(pin_q[i]));
    endtask

    initial begin
        int target, n;
        apply_reset(3);
        repeat (2) @(posedge clk);

        // len 8, two full words, link always ready
        ready_mode = 0;
        mem[0] = 32'h11223344; mem[1] = 32'h55667788;
        do_run(16'd8, 0);
        pin_q = '{8'h00, 8'h08, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        pin_check("t1_bytes");

        // len 6, partial final word
        mem[0] = 32'hAABBCCDD; mem[1] = 32'hEEFF0011;
        do_run(16'd6, 0);
        pin_q = '{8'h00, 8'h06, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        pin_check("t2_bytes");
        check("t2_last_addr", 32'(max_seen), 32'd1);

        // len 0: prefix only
        do_run(16'd0, 0);
        pin_q = '{8'h00, 8'h00};
        pin_check("t3_bytes");
        check("t3_no_read_addr", 32'(max_seen), 32'd0);

        // len 12 with random backpressure and an ignored second run
        ready_mode = 2;
        mem[0] = 32'h01020304; mem[1] = 32'h05060708; mem[2] = 32'h090A0B0C;
        do_run(16'd12, 1);
        pin_q = '{8'h00, 8'h0C, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                  8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        pin_check("t4_bytes");

        // len 0xFFFF clamps to the 16-byte capacity
        ready_mode = 1;
        mem[0] = 32'hA0A1A2A3; mem[1] = 32'hB0B1B2B3;
        mem[2] = 32'hC0C1C2C3; mem[3] = 32'hD0D1D2D3;
        do_run(16'hFFFF, 0);
        pin_q = '{8'h00, 8'h10, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2,
                  8'hB3, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0, 8'hD1, 8'hD2, 8'hD3};
        pin_check("t5_bytes");

        // random lengths, contents and backpressure
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < 2**ADR_W; i++) mem[i] = $urandom;
            ready_mode = $urandom_range(0, 2);
            if ($urandom_range(0, 4) == 0) do_run(16'($urandom), 0);
            else                           do_run(16'($urandom_range(0, 20)), 0);
        end

        // reset after the prefix and 3 payload bytes, then a fresh drain
        ready_mode = 0;
        mem[0] = 32'h11223344; mem[1] = 32'h55667788;
        target = xfer_cnt + 5;
        start_run(16'd8);
        n = 0;
        while (xfer_cnt < target && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check("t6_reached_bytes", 32'(xfer_cnt), 32'(target));
        force_ready_low = 1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        force_ready_low = 0;
        @(negedge clk);
        check("t6_busy_after_rst", 32'(dpram_busy), 32'd0);
        check("t6_valid_after_rst", 32'(tx_valid), 32'd0);
        pin_q = '{8'h00, 8'h08, 8'h11, 8'h22, 8'h33};
        pin_check("t6_partial");
        mem[0] = 32'hDEADBEEF;
        do_run(16'd4, 0);
        pin_q = '{8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        pin_check("t6_bytes");

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
